// File: rtl/redmule_tcdm_responder.sv
// TCDM-side responder for the RedMulE wide port: word-organised backing store plus an
// ordered response FIFO with lrdy backpressure. Optional grant stalling: REDMULE_TCDM_RESP_STALL_EN.
module redmule_tcdm_responder #(
  parameter int unsigned DATA_W    = 160,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                wen_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [31:0]         add_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                lrdy_i,
  input  logic                user_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic [DATA_W-1:0]   r_data_o,
  output logic                r_opc_o,
  output logic                r_user_o
);

  localparam int unsigned NW = DATA_W / 32;
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [31:0]       r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_fifo_data [RSP_DEPTH];
  logic              r_fifo_opc  [RSP_DEPTH];
  logic              r_fifo_user [RSP_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_pend_vld;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_pend_opc;
  logic              r_pend_user;

  logic [AW-1:0]     w_idx [NW];
  logic [DATA_W-1:0] w_rd_data;
  logic [CW:0]       w_occ;
  logic              w_misal;
  logic              w_stall;
  logic              w_gnt;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_empty;
  logic              w_pop;
  logic              w_fifo_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_opc;
  logic              w_head_user;
  logic              w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign w_unused = ^add_i[31:AW+2];

  // Lane k addresses word (base + k), wrapping naturally at the top of the store
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    for (int k = 0; k < NW; k++) begin
      w_idx[k] = add_i[AW+1:2] + AW'(k);
      w_rd_data[k*32 +: 32] = r_mem[w_idx[k]];
    end
  end

`ifdef REDMULE_TCDM_RESP_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Occupancy counts the pending stage so every granted read has a reserved FIFO slot
  assign w_occ   = {1'b0, r_cnt} + (CW+1)'(r_pend_vld);
  assign w_misal = (add_i[1:0] != 2'b00);
  assign w_gnt   = req_i && !rst_i && !w_stall && (w_occ < (CW+1)'(RSP_DEPTH));
  assign w_wr_en = w_gnt && !wen_i && !w_misal;
  assign w_rd_en = w_gnt && wen_i;
  assign gnt_o   = w_gnt;

  // With an empty FIFO the pending stage is presented directly, giving one-cycle read latency
  assign w_empty     = (r_cnt == CW'(0));
  assign w_head_data = w_empty ? r_pend_data : r_fifo_data[r_rd_ptr];
  assign w_head_opc  = w_empty ? r_pend_opc  : r_fifo_opc[r_rd_ptr];
  assign w_head_user = w_empty ? r_pend_user : r_fifo_user[r_rd_ptr];

  assign r_valid_o  = !w_empty || r_pend_vld;
  assign r_data_o   = r_valid_o ? w_head_data : {DATA_W{1'b0}};
  assign r_opc_o    = r_valid_o && w_head_opc;
  assign r_user_o   = r_valid_o && w_head_user;

  assign w_pop      = r_valid_o && lrdy_i;
  assign w_fifo_pop = w_pop && !w_empty;
  assign w_push     = r_pend_vld && !(w_pop && w_empty);

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < NW; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[k*4+b]) begin
            r_mem[w_idx[k]][b*8 +: 8] <= data_i[k*32+b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rd_en) begin
      r_pend_data <= w_misal ? {DATA_W{1'b0}} : w_rd_data;
      r_pend_opc  <= w_misal;
      r_pend_user <= user_i;
    end
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_pend_data;
      r_fifo_opc[r_wr_ptr]  <= r_pend_opc;
      r_fifo_user[r_wr_ptr] <= r_pend_user;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_vld <= 1'b0;
      r_rd_ptr   <= {PW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_cnt      <= {CW{1'b0}};
    end else begin
      r_pend_vld <= w_rd_en;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed self-checking bench for redmule_tcdm_responder (default build, no grant stalling).
module tb_redmule_tcdm_responder;

  localparam logic [159:0] D1 = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [159:0] D2 = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'hFFFFFFFF};
  localparam logic [159:0] D0 = {32'hD0D00004, 32'hD0D00003, 32'hD0D00002, 32'hD0D00001, 32'hD0D00000};
  localparam logic [159:0] D3 = {32'hE3E30004, 32'hE3E30003, 32'hE3E30002, 32'hE3E30001, 32'hE3E30000};
  localparam logic [159:0] W0 = {32'hD0D00004, 32'hD0D00003, 32'hE3E30004, 32'hE3E30003, 32'hE3E30002};
  localparam logic [159:0] ONES = {160{1'b1}};
  localparam logic [159:0] DE   = {20{8'hDE}};
  localparam logic [159:0] SEVS = {20{8'h77}};

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         wen_i = 1'b0;
  logic [19:0]  be_i = 20'h0;
  logic [31:0]  add_i = 32'h0;
  logic [159:0] data_i = 160'h0;
  logic         lrdy_i = 1'b1;
  logic         user_i = 1'b0;
  logic         gnt_o, r_valid_o, r_opc_o, r_user_o;
  logic [159:0] r_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [159:0] q_data[$];
  logic         q_opc[$];
  logic         q_user[$];

  redmule_tcdm_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wen_i(wen_i), .be_i(be_i),
    .add_i(add_i), .data_i(data_i), .lrdy_i(lrdy_i), .user_i(user_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
    .r_opc_o(r_opc_o), .r_user_o(r_user_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grant and the expected response head mid-cycle
  task automatic cyc(input logic rst, input logic req, input logic wen, input logic [31:0] a,
                     input logic [19:0] be, input logic [159:0] d, input logic u, input logic lr,
                     input logic eg, input logic [159:0] ed, input logic eo);
    @(negedge clk_i);
    rst_i = rst; req_i = req; wen_i = wen; add_i = a; be_i = be; data_i = d;
    user_i = u; lrdy_i = lr;
    #1;
    check("gnt", gnt_o, eg);
    check("r_valid", r_valid_o, q_data.size() != 0);
    if (r_valid_o && q_data.size() != 0) begin
      check("r_data", r_data_o, q_data[0]);
      check("r_opc", r_opc_o, q_opc[0]);
      check("r_user", r_user_o, q_user[0]);
      if (lr) begin
        void'(q_data.pop_front());
        void'(q_opc.pop_front());
        void'(q_user.pop_front());
      end
    end
    if (gnt_o && req && wen) begin
      q_data.push_back(ed);
      q_opc.push_back(eo);
      q_user.push_back(u);
    end
    if (rst) begin
      q_data.delete();
      q_opc.delete();
      q_user.delete();
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [19:0] be, input logic [159:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, be, d, 1'b0, 1'b1, 1'b1, 160'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic u, input logic [159:0] ed, input logic eo);
    cyc(1'b0, 1'b1, 1'b1, a, 20'h0, 160'h0, u, 1'b1, 1'b1, ed, eo);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 20'h0, 160'h0, 1'b0, 1'b1, 1'b0, 160'h0, 1'b0);
  endtask

  task automatic quiet_after_reset();
    @(posedge clk_i);
    #1;
    check("rst_valid", r_valid_o, 1'b0);
    check("rst_data", r_data_o, 160'h0);
    check("rst_opc", r_opc_o, 1'b0);
    check("rst_user", r_user_o, 1'b0);
  endtask

  initial begin
    // reset with a write request present: no grant
    cyc(1'b1, 1'b1, 1'b0, 32'h100, 20'hFFFFF, DE, 1'b0, 1'b1, 1'b0, 160'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h100, 20'hFFFFF, DE, 1'b0, 1'b1, 1'b0, 160'h0, 1'b0);
    quiet_after_reset();

    // full write then read-back, one-cycle latency
    wr(32'h100, 20'hFFFFF, D1);
    rd(32'h100, 1'b0, D1, 1'b0);
    idle();

    // partial byte enables, read in the cycle right after the write
    wr(32'h100, 20'h0000F, ONES);
    rd(32'h100, 1'b1, D2, 1'b0);
    idle();

    // wrap at the top of the store: word 4094 spills lanes 2..4 into words 0..2
    wr(32'h0, 20'hFFFFF, D0);
    wr(32'h3FF8, 20'hFFFFF, D3);
    rd(32'h3FF8, 1'b0, D3, 1'b0);
    rd(32'h0, 1'b1, W0, 1'b0);
    idle();

    // misaligned read errors, misaligned write is dropped
    rd(32'h102, 1'b1, 160'h0, 1'b1);
    wr(32'h102, 20'hFFFFF, SEVS);
    rd(32'h100, 1'b0, D2, 1'b0);
    idle();

    // backpressure: four grants, then stall until a pop
    cyc(1'b0, 1'b1, 1'b1, 32'h100,  20'h0, 160'h0, 1'b0, 1'b0, 1'b1, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0,    20'h0, 160'h0, 1'b1, 1'b0, 1'b1, W0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h102,  20'h0, 160'h0, 1'b0, 1'b0, 1'b1, 160'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h3FF8, 20'h0, 160'h0, 1'b1, 1'b0, 1'b1, D3, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100,  20'h0, 160'h0, 1'b0, 1'b0, 1'b0, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100,  20'h0, 160'h0, 1'b0, 1'b0, 1'b0, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100,  20'h0, 160'h0, 1'b0, 1'b1, 1'b0, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100,  20'h0, 160'h0, 1'b0, 1'b1, 1'b1, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h3FF8, 20'h0, 160'h0, 1'b1, 1'b1, 1'b1, D3, 1'b0);
    for (int i = 0; i < 6; i++) idle();

    // sustained one read per cycle with lrdy held high
    rd(32'h100,  1'b0, D2, 1'b0);
    rd(32'h0,    1'b1, W0, 1'b0);
    rd(32'h3FF8, 1'b0, D3, 1'b0);
    rd(32'h102,  1'b1, 160'h0, 1'b1);
    rd(32'h100,  1'b1, D2, 1'b0);
    idle();
    idle();

    // reset with three queued responses and a write in the reset cycle
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 20'h0, 160'h0, 1'b0, 1'b0, 1'b1, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 20'h0, 160'h0, 1'b1, 1'b0, 1'b1, D2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h100, 20'h0, 160'h0, 1'b0, 1'b0, 1'b1, D2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h100, 20'hFFFFF, DE, 1'b0, 1'b0, 1'b0, 160'h0, 1'b0);
    quiet_after_reset();
    for (int i = 0; i < 3; i++) idle();
    rd(32'h100, 1'b0, D2, 1'b0);
    rd(32'h0, 1'b0, W0, 1'b0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
